nice_frame_packer: RTL
======================

Name: nice_frame_packer

Overview:
- Downstream of the demodulator/top signal chain.
- On each frame tick, snapshots a flat bus of NUM_WORDS 32-bit results: raw ADC words, OPD x/y, shear/pointing x/y/i, and the sample counter.
- Emits each snapshot as a framed word stream over a valid/ready interface toward the PS-side DMA/FIFO.
- Double-buffered, so the stream consumer may stall for up to one frame time without loss.

Parameters:
- NUM_WORDS, 25, number of 32-bit payload words per frame (1..255).
- SYNC_WORD, 16'h5AC3, upper half of the header word.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset: asynchronous, active-low.
- tick_i  in  1  one-cycle snapshot strobe (demodulator done).
- words_i  in  32*NUM_WORDS  payload; word k = words_i[32k+31:32k].
- data_o  out  32  stream data.
- valid_o  out  1  stream data valid.
- ready_i  in  1  consumer ready.
- last_o  out  1  marks final beat of a frame.
- seq_o  out  16  sequence number of the most recently captured frame.
- drop_count_o  out  16  frames dropped, saturating.
- overflow_o  out  1  sticky; set on any drop.

Behaviour:
- Reset (reset_i low, async): state IDLE, both banks empty, bank pointers 0, seq 0, data_o 0, valid_o 0, last_o 0, drop_count_o 0, overflow_o 0. Bank contents are don't-care.
- Storage: two banks of NUM_WORDS x 32. wr_bank and rd_bank are 1-bit pointers; full_cnt ranges 0..2.
- Capture: tick_i high and (full_cnt<2, or the frame-final beat is accepted this cycle) ->
  - words_i written into bank wr_bank at that edge;
  - wr_bank toggles; seq increments (wraps 0xFFFF->0x0000);
  - seq_o updates the cycle after tick;
  - the header of this frame carries the new seq value.
- Drop: tick_i with full_cnt==2 and no final beat accepted ->
  - no capture;
  - drop_count_o += 1, saturating at 0xFFFF;
  - overflow_o set, cleared only by reset;
  - seq unchanged.
- Simultaneous capture and frame completion: full_cnt unchanged; rd_bank and wr_bank both toggle.
- FSM states:
  - IDLE: valid_o 0. If full_cnt>0 -> HEADER.
  - HEADER: data_o = {SYNC_WORD, seq of frame in rd_bank}; the seq is stored per bank at capture. On handshake -> PAYLOAD with idx=0.
  - PAYLOAD: data_o = bank[rd_bank][idx]. On handshake, idx++. At idx==NUM_WORDS-1 the handshake leads -> CHECKSUM if enabled; otherwise it is the last beat and goes -> IDLE, or -> HEADER directly if another bank is full.
  - CHECKSUM: see Optional Feature. On handshake -> IDLE/HEADER as above.
- Handshake:
  - A beat transfers when valid_o && ready_i at a rising edge.
  - Once valid_o is asserted, data_o/last_o stay stable until the beat transfers.
  - valid_o never deasserts without a transfer except by reset.
- On frame completion, rd_bank toggles and full_cnt decrements.
- Outputs are registered. Latency from tick_i (cycle n, banks empty, FSM idle) to header valid: cycle n+2.
- Back-to-back frames: no idle cycle between the last beat of frame A and the header of frame B.
- Reset mid-frame: the stream aborts immediately, valid_o drops asynchronously, and there is no partial-frame recovery.
- ready_i held high: frame of NUM_WORDS+2 beats (with checksum) in NUM_WORDS+2 consecutive cycles.

Optional Feature:
- Macro FRAME_PACKER_CHECKSUM_EN.
- Defined: after the payload, one extra beat, data_o = XOR of the header word and all NUM_WORDS payload words. last_o is asserted on this beat only. Frame length is NUM_WORDS+2.
- Undefined: no CHECKSUM state. last_o is asserted on payload word NUM_WORDS-1. Frame length is NUM_WORDS+1.

Test Plan:
- Reset, NUM_WORDS=4, ready_i=1, tick with words {1,2,3,4} ->
  - beats 0x5AC30001, 1, 2, 3, 4;
  - checksum 0x5AC30001^1^2^3^4 = 0x5AC30005 with last_o=1;
  - seq_o=1.
- ready_i=0, three ticks ->
  - first two captured; third dropped;
  - drop_count_o=1, overflow_o=1;
  - after ready_i=1, frames seq 1 then 2 stream back-to-back with no gap cycle.
- Final beat accepted in the same cycle as a tick with full_cnt==2 -> no drop, new frame seq 3 queued, full_cnt stays 2.
- Random ready_i toggling during a frame -> data_o/last_o stable while valid_o && !ready_i; payload order 0..NUM_WORDS-1 is preserved.
- Force seq to 0xFFFF, then tick ->
  - header 0x5AC30000;
  - drop_count_o saturation at 0xFFFF with 70000 forced drops.
- Assert reset_i low mid-payload ->
  - valid_o=0 and drop_count_o=0 without waiting for a clock edge;
  - after release, a new tick yields header 0x5AC30001.

Source files
------------

// File: rtl/nice_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : nice_frame_packer
// Brief    : Snapshots NUM_WORDS 32-bit results on each frame tick into one
//            of two banks. Streams each snapshot as a framed valid/ready word
//            sequence: header {SYNC_WORD, seq}, then the payload words, then
//            an optional XOR checksum beat.
//            Optional feature macro: FRAME_PACKER_CHECKSUM_EN (appends the
//            checksum beat and moves last_o onto it).
// Revision : 1.0 - initial release
// ============================================================================
module nice_frame_packer #(
  parameter int          NUM_WORDS = 25,
  parameter logic [15:0] SYNC_WORD = 16'h5AC3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    tick_i,
  input  logic [32*NUM_WORDS-1:0] words_i,
  output logic [31:0]             data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic [15:0]             seq_o,
  output logic [15:0]             drop_count_o,
  output logic                    overflow_o
);

  localparam int c_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);
`ifdef FRAME_PACKER_CHECKSUM_EN
  localparam bit c_CSUM_EN = 1'b1;
`else
  localparam bit c_CSUM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HEADER   = 2'd1,
`ifdef FRAME_PACKER_CHECKSUM_EN
    ST_PAYLOAD  = 2'd2,
    ST_CHECKSUM = 2'd3
`else
    ST_PAYLOAD  = 2'd2
`endif
  } state_t;

  // Snapshot storage; contents need no reset.
  logic [31:0]        r_bank     [2][NUM_WORDS];
  logic [15:0]        r_bank_seq [2];

  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [1:0]         r_full_cnt;
  logic [15:0]        r_seq;
  logic [15:0]        r_drop_cnt;
  logic               r_overflow;

  state_t             r_state, w_state_nxt;
  logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [31:0]        r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_last, w_last_nxt;
`ifdef FRAME_PACKER_CHECKSUM_EN
  logic [31:0]        r_csum;
`endif

  logic               w_fire;
  logic               w_done;
  logic               w_capture;
  logic               w_drop;
  logic [15:0]        w_seq_inc;
  logic [c_IDX_W-1:0] w_idx_inc;

  // A frame finishes when its last-flagged beat transfers; that frees a bank
  // in the same cycle, so a tick arriving then is still captured.
  assign w_fire    = r_valid & ready_i;
  assign w_done    = w_fire & r_last;
  assign w_capture = tick_i & (~r_full_cnt[1] | w_done);
  assign w_drop    = tick_i & ~w_capture;
  assign w_seq_inc = r_seq + 16'd1;
  assign w_idx_inc = r_idx + c_IDX_W'(1);

  // Write the snapshot and its sequence number into the free bank.
  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_bank[r_wr_bank][k] <= words_i[32*k +: 32];
      end
      r_bank_seq[r_wr_bank] <= w_seq_inc;
    end
  end

  // Bank pointers, occupancy, sequence and drop bookkeeping.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_full_cnt <= 2'd0;
      r_seq      <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wr_bank <= ~r_wr_bank;
        r_seq     <= w_seq_inc;
      end
      if (w_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
      r_full_cnt <= r_full_cnt + {1'b0, w_capture} - {1'b0, w_done};
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

`ifdef FRAME_PACKER_CHECKSUM_EN
  // Running XOR of every beat already sent in the current frame.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_csum <= 32'd0;
    end else if (w_fire) begin
      if (r_state == ST_HEADER) begin
        r_csum <= r_data;
      end else if (r_state == ST_PAYLOAD) begin
        r_csum <= r_csum ^ r_data;
      end
    end
  end
`endif

  // Stream FSM state and registered output beat.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= 32'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next beat selection; an unaccepted beat is simply held.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (r_full_cnt != 2'd0) begin
          w_state_nxt = ST_HEADER;
          w_data_nxt  = {SYNC_WORD, r_bank_seq[r_rd_bank]};
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
        end
      end
      ST_HEADER: begin
        if (w_fire) begin
          w_state_nxt = ST_PAYLOAD;
          w_idx_nxt   = '0;
          w_data_nxt  = r_bank[r_rd_bank][0];
          w_last_nxt  = !c_CSUM_EN && (NUM_WORDS == 1);
        end
      end
      ST_PAYLOAD: begin
        if (w_fire) begin
          if (r_idx == c_LAST_IDX) begin
`ifdef FRAME_PACKER_CHECKSUM_EN
            w_state_nxt = ST_CHECKSUM;
            w_data_nxt  = r_csum ^ r_data;
            w_last_nxt  = 1'b1;
`endif
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_data_nxt = r_bank[r_rd_bank][w_idx_inc];
            w_last_nxt = !c_CSUM_EN && (w_idx_inc == c_LAST_IDX);
          end
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
    // Frame completion: chain straight into the other bank's header when it
    // is already full, otherwise fall back to idle.
    if (w_done) begin
      if (r_full_cnt == 2'd2) begin
        w_state_nxt = ST_HEADER;
        w_data_nxt  = {SYNC_WORD, r_bank_seq[~r_rd_bank]};
        w_valid_nxt = 1'b1;
        w_last_nxt  = 1'b0;
      end else begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign last_o       = r_last;
  assign seq_o        = r_seq;
  assign drop_count_o = r_drop_cnt;
  assign overflow_o   = r_overflow;

endmodule
`default_nettype wire
